// File: rtl/ysyx_25060170_lsu.sv
// Load/store unit between EXU and WBU: aligns and sign-extends loads, replicates store data,
// flags malformed/misaligned accesses and aborts memory transactions that exceed a cycle budget.
module ysyx_25060170_lsu #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic        in_mem_rd,
    input  logic        in_mem_wr,
    input  logic [2:0]  in_funct3,
    input  logic [4:0]  in_rd,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [15:0] LAST_CNT = 16'(TIMEOUT_CYC - 1);

    state_t      state_reg, state_next;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wmask_reg;
    logic        wr_reg;
    logic [2:0]  funct3_reg;
    logic [4:0]  dest_reg;
    logic [31:0] data_reg;
    logic        err_reg;
    logic [15:0] cnt_reg;

    logic        is_mem;
    logic        misaligned;
    logic        dec_err;
    logic [3:0]  dec_mask;
    logic [31:0] dec_wdata;
    logic        timeout;
    logic [31:0] lane;
    logic [31:0] load_data;

    // Request decode on the incoming EXU result; funct3[1:0] encodes access size.
    always_comb begin
        is_mem     = in_mem_rd | in_mem_wr;
        misaligned = 1'b0;
        dec_mask   = 4'b1111;
        dec_wdata  = in_wdata;
        case (in_funct3[1:0])
            2'b00: begin
                dec_mask  = 4'b0001 << in_addr[1:0];
                dec_wdata = {4{in_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = in_addr[0];
                dec_mask   = 4'b0011 << in_addr[1:0];
                dec_wdata  = {2{in_wdata[15:0]}};
            end
            2'b10: misaligned = (in_addr[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        if (!in_mem_wr) begin
            dec_mask = 4'b0000;
        end

        dec_err = 1'b0;
        if (in_mem_rd && in_mem_wr) begin
            dec_err = 1'b1;
        end else if (in_mem_rd) begin
            dec_err = (in_funct3 == 3'd3) || (in_funct3[2:1] == 2'b11) || misaligned;
        end else if (in_mem_wr) begin
            dec_err = (in_funct3 > 3'd2) || misaligned;
        end
    end

    always_comb begin
        lane = mem_rdata >> {addr_reg[1:0], 3'b000};
        case (funct3_reg)
            3'd0:    load_data = {{24{lane[7]}}, lane[7:0]};
            3'd1:    load_data = {{16{lane[15]}}, lane[15:0]};
            3'd4:    load_data = {24'd0, lane[7:0]};
            3'd5:    load_data = {16'd0, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    // A completing handshake/response on the last budget cycle wins over the abort.
    always_comb begin
        state_next = state_reg;
        timeout    = (cnt_reg == LAST_CNT);
        case (state_reg)
            IDLE: if (in_valid) state_next = (dec_err || !is_mem) ? DONE : REQ;
            REQ: begin
                if (mem_req_ready)  state_next = WAIT;
                else if (timeout)   state_next = DONE;
            end
            WAIT: begin
                if (mem_resp_valid) state_next = DONE;
                else if (timeout)   state_next = DONE;
            end
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            wmask_reg  <= '0;
            wr_reg     <= 1'b0;
            funct3_reg <= '0;
            dest_reg   <= '0;
            data_reg   <= '0;
            err_reg    <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: if (in_valid) begin
                    addr_reg   <= in_addr;
                    wdata_reg  <= dec_wdata;
                    wmask_reg  <= dec_mask;
                    wr_reg     <= in_mem_wr;
                    funct3_reg <= in_funct3;
                    dest_reg   <= in_rd;
                    err_reg    <= dec_err;
                    data_reg   <= (dec_err || is_mem) ? 32'd0 : in_addr;
                    cnt_reg    <= '0;
                end
                REQ, WAIT: begin
                    cnt_reg <= cnt_reg + 16'd1;
                    if (state_next == DONE) begin
                        if (state_reg == WAIT && mem_resp_valid) begin
                            if (!wr_reg) data_reg <= load_data;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = (state_reg == IDLE);
    assign mem_req_valid = (state_reg == REQ);
    assign mem_addr      = {addr_reg[31:2], 2'b00};
    assign mem_wen       = (state_reg == REQ) && wr_reg;
    assign mem_wmask     = (state_reg == REQ) ? wmask_reg : 4'b0000;
    assign mem_wdata     = wdata_reg;
    assign out_valid     = (state_reg == DONE);
    assign out_data      = data_reg;
    assign out_rd        = dest_reg;
    assign out_err       = err_reg;

endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
// Directed bench for the LSU: a spec-level model predicts every visible cycle of each
// transaction, a per-cycle compare process checks it, and literal results pin the model.
module tb_ysyx_25060170_lsu;
    localparam int T = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic        in_mem_rd;
    logic        in_mem_wr;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_err;

    ysyx_25060170_lsu #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_mem_rd(in_mem_rd), .in_mem_wr(in_mem_wr), .in_funct3(in_funct3), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_err(out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        chk_en = 1'b0;
    logic        exp_out_on = 1'b0;
    logic        exp_mem_on = 1'b0;
    logic [31:0] exp_data, exp_maddr, exp_wdata;
    logic [4:0]  exp_rd;
    logic        exp_err, exp_wen;
    logic [3:0]  exp_wmask;

    logic [31:0] g_data, g_addr, g_wdata;
    logic        g_err;
    logic [3:0]  g_mask;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Expected architectural result of one request, straight from the access rules.
    function automatic void model(input logic [31:0] a, input logic [31:0] w, input logic rd_,
                                  input logic wr_, input logic [2:0] f, input logic [31:0] rdata,
                                  output logic err, output logic mem, output logic [31:0] data,
                                  output logic [3:0] mask, output logic [31:0] wd);
        int sz, off;
        logic [7:0]  b;
        logic [15:0] h;
        sz  = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        off = int'(a[1:0]);
        err = 1'b0;
        if (rd_ && wr_) err = 1'b1;
        if (rd_ && !wr_ && (f == 3'd3 || f == 3'd6 || f == 3'd7)) err = 1'b1;
        if (wr_ && !rd_ && f >= 3'd3) err = 1'b1;
        if ((rd_ || wr_) && !err && (off % sz) != 0) err = 1'b1;
        mem  = (rd_ || wr_) && !err;
        mask = 4'b0000;
        wd   = 32'd0;
        if (mem && wr_) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= off && i < off + sz) mask[i] = 1'b1;
                wd[8*i +: 8] = w[8*(i % sz) +: 8];
            end
        end
        b = rdata[8*off +: 8];
        h = (off <= 2) ? rdata[8*off +: 16] : 16'd0;
        if (err)               data = 32'd0;
        else if (!rd_ && !wr_) data = a;
        else if (wr_)          data = 32'd0;
        else begin
            case (f)
                3'd0:    data = {{24{b[7]}}, b};
                3'd1:    data = {{16{h[15]}}, h};
                3'd4:    data = {24'd0, b};
                3'd5:    data = {16'd0, h};
                default: data = rdata;
            endcase
        end
    endfunction

    // Per-cycle compare, sampled just after the falling edge.
    always begin
        @(negedge clk);
        #1;
        if (!rst && chk_en) begin
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_out_on});
            if (exp_out_on) begin
                check("out_data", out_data, exp_data);
                check("out_rd", {27'd0, out_rd}, {27'd0, exp_rd});
                check("out_err", {31'd0, out_err}, {31'd0, exp_err});
            end
            check("mem_req_valid", {31'd0, mem_req_valid}, {31'd0, exp_mem_on});
            if (exp_mem_on) begin
                check("mem_addr", mem_addr, exp_maddr);
                check("mem_wen", {31'd0, mem_wen}, {31'd0, exp_wen});
                check("mem_wmask", {28'd0, mem_wmask}, {28'd0, exp_wmask});
                if (exp_wen) check("mem_wdata", mem_wdata, exp_wdata);
            end
        end
    end

    // Starts and ends on a falling edge with the LSU idle. r = cycles before mem_req_ready,
    // d = WAIT cycles before the response, hold = cycles out_ready is held low.
    task automatic run_op(input logic [31:0] a, input logic [31:0] w, input logic rd_,
                          input logic wr_, input logic [2:0] f, input logic [4:0] dst,
                          input logic [31:0] rdata, input int r, input int d, input int hold);
        logic m_err, m_mem;
        logic [31:0] m_data, m_wd;
        logic [3:0] m_mask;
        int n;
        bit tmo;
        model(a, w, rd_, wr_, f, rdata, m_err, m_mem, m_data, m_mask, m_wd);
        g_addr = 32'd0; g_wdata = 32'd0; g_mask = 4'd0;
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_addr = a; in_wdata = w; in_mem_rd = rd_; in_mem_wr = wr_;
        in_funct3 = f; in_rd = dst;
        @(negedge clk);
        in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom;
        in_mem_rd = 1'b0; in_mem_wr = 1'b0; in_funct3 = 3'($urandom); in_rd = 5'($urandom);
        exp_rd = dst; exp_maddr = {a[31:2], 2'b00}; exp_wen = wr_;
        exp_wmask = m_mask; exp_wdata = m_wd;
        if (m_mem) begin
            tmo = (r + d + 2 > T);
            n   = tmo ? T : r + d + 2;
            for (int i = 0; i < n; i++) begin
                exp_mem_on     = (i <= r);
                mem_req_ready  = (i == r);
                mem_resp_valid = (i == r + 1 + d);
                mem_rdata      = (i == r + 1 + d) ? rdata : $urandom;
                if (i == 0) begin
                    g_addr = mem_addr; g_wdata = mem_wdata; g_mask = mem_wmask;
                end
                @(negedge clk);
            end
            mem_req_ready = 1'b0; mem_resp_valid = 1'b0; exp_mem_on = 1'b0;
            if (tmo) begin
                m_err = 1'b1; m_data = 32'd0;
            end
        end
        exp_data = m_data; exp_err = m_err; exp_out_on = 1'b1;
        g_data = out_data; g_err = out_err;
        for (int k = 0; k < hold; k++) begin
            check("in_ready_busy", {31'd0, in_ready}, 32'd0);
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0; exp_out_on = 1'b0;
        $display("op addr=%h wdata=%h rd=%0d wr=%0d f3=%0d -> data=%h err=%0d", a, w, rd_, wr_, f,
                 g_data, g_err);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_mem_rd = 1'b0;
        in_mem_wr = 1'b0; in_funct3 = '0; in_rd = '0; mem_req_ready = 1'b0;
        mem_resp_valid = 1'b0; mem_rdata = '0; out_ready = 1'b0;
        exp_data = '0; exp_maddr = '0; exp_wdata = '0; exp_rd = '0; exp_err = 1'b0;
        exp_wen = 1'b0; exp_wmask = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_outputs", {mem_req_valid, mem_wen, mem_wmask, out_valid, out_err, out_rd},
              32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        chk_en = 1'b1;

        run_op(32'h8000_0003, 32'h0, 1'b1, 1'b0, 3'd0, 5'd3, 32'h8000_0000, 0, 0, 0);
        check("lb_data", g_data, 32'hFFFF_FF80);
        check("lb_addr", g_addr, 32'h8000_0000);
        check("lb_err", {31'd0, g_err}, 32'd0);

        run_op(32'h0000_0102, 32'h1234_ABCD, 1'b0, 1'b1, 3'd1, 5'd4, 32'h0, 0, 0, 1);
        check("sh_wdata", g_wdata, 32'hABCD_ABCD);
        check("sh_wmask", {28'd0, g_mask}, 32'hC);
        check("sh_data", g_data, 32'd0);

        run_op(32'h0000_0006, 32'h0, 1'b1, 1'b0, 3'd2, 5'd5, 32'h0, 0, 0, 0);
        check("lw_misalign_err", {31'd0, g_err}, 32'd1);
        run_op(32'h0000_0100, 32'h0, 1'b1, 1'b1, 3'd2, 5'd6, 32'h0, 0, 0, 0);
        check("rdwr_err", {31'd0, g_err}, 32'd1);

        run_op(32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, 3'd7, 5'd9, 32'h0, 0, 0, 5);
        check("pass_data", g_data, 32'hDEAD_BEEF);

        run_op(32'h0000_0203, 32'h0000_0055, 1'b0, 1'b1, 3'd0, 5'd1, 32'h0, 1, 1, 0);
        check("sb_wmask", {28'd0, g_mask}, 32'h8);
        check("sb_wdata", g_wdata, 32'h5555_5555);
        run_op(32'h0000_0400, 32'hCAFE_F00D, 1'b0, 1'b1, 3'd2, 5'd2, 32'h0, 0, 1, 0);
        run_op(32'h0000_0010, 32'h0, 1'b1, 1'b0, 3'd1, 5'd10, 32'h0000_8001, 0, 0, 0);
        check("lh_data", g_data, 32'hFFFF_8001);
        run_op(32'h0000_0012, 32'h0, 1'b1, 1'b0, 3'd5, 5'd11, 32'hBEEF_1234, 0, 0, 2);
        check("lhu_data", g_data, 32'h0000_BEEF);
        run_op(32'h0000_0020, 32'h0, 1'b1, 1'b0, 3'd2, 5'd12, 32'h89AB_CDEF, 1, 0, 0);
        check("lw_data", g_data, 32'h89AB_CDEF);
        run_op(32'h0000_0020, 32'h0, 1'b1, 1'b0, 3'd6, 5'd13, 32'h0, 0, 0, 0);
        run_op(32'h0000_0020, 32'h0, 1'b0, 1'b1, 3'd3, 5'd14, 32'h0, 0, 0, 0);
        run_op(32'h0000_0011, 32'h0, 1'b1, 1'b0, 3'd1, 5'd15, 32'h0, 0, 0, 0);

        // Request never accepted: abort after the budget, then a stray response in IDLE.
        run_op(32'h0000_0040, 32'h0, 1'b1, 1'b0, 3'd2, 5'd16, 32'h1111_1111, 10, 0, 2);
        check("timeout_err", {31'd0, g_err}, 32'd1);
        mem_resp_valid = 1'b1; mem_rdata = 32'h2222_2222;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("late_resp_idle", {31'd0, in_ready}, 32'd1);
        // Accepted but the response comes too late: abort from WAIT.
        run_op(32'h0000_0044, 32'h0, 1'b1, 1'b0, 3'd2, 5'd17, 32'h3333_3333, 1, 2, 0);
        check("timeout_wait_err", {31'd0, g_err}, 32'd1);

        // Reset while waiting for a response.
        in_valid = 1'b1; in_addr = 32'h0000_0100; in_mem_rd = 1'b1; in_mem_wr = 1'b0;
        in_funct3 = 3'd2; in_rd = 5'd7;
        @(negedge clk);
        in_valid = 1'b0; in_mem_rd = 1'b0;
        exp_maddr = 32'h0000_0100; exp_wen = 1'b0; exp_wmask = 4'd0; exp_mem_on = 1'b1;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0; exp_mem_on = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("op reset during WAIT");
        check("rstw_in_ready", {31'd0, in_ready}, 32'd1);
        check("rstw_out_valid", {31'd0, out_valid}, 32'd0);
        check("rstw_mem_addr", mem_addr, 32'd0);
        check("rstw_out_data", out_data, 32'd0);
        run_op(32'h0000_0201, 32'h0, 1'b1, 1'b0, 3'd4, 5'd18, 32'h0000_F100, 0, 0, 0);
        check("lbu_data", g_data, 32'h0000_00F1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
